tx_setting_ctrl: RTL and testbench

//  Runtime sequencer for the TX FFE driver. Owns the emphasis setting index fed to a

---
 rtl/tx_setting_ctrl_pkg.sv | 29 ++
 rtl/tx_dwell_timer.sv | 33 +++
 rtl/tx_setting_ctrl.sv | 143 ++++++++++++++
 tb/tb_tx_setting_ctrl.sv | 347 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tx_setting_ctrl_pkg.sv
// Shared constants and types for the TX emphasis-setting sequencer and its driver.
package tx_setting_ctrl_pkg;

    // Length of the FFE delay line in tx_driver; one mute phase flushes this many symbols.
    localparam int N_TAPS        = 5;

    // Number of entries in the driver's tap tables.
    localparam int N_TX_SETTINGS = 11;
    localparam int SETTING_WIDTH = $clog2(N_TX_SETTINGS);

    // Width of the mute-phase symbol counter (at least one bit).
    localparam int CNT_WIDTH     = (N_TAPS > 1) ? $clog2(N_TAPS) : 1;

    // Setting index as seen on the tx_driver setting port.
    typedef logic [SETTING_WIDTH-1:0] SETTING_FORMAT;

    // Sequencer phases: passing data, flushing the old setting, filling with the new one.
    typedef enum logic [1:0] {
        ACTIVE = 2'd0,
        DRAIN  = 2'd1,
        SETTLE = 2'd2
    } tx_ctrl_state_t;

    // Setting that follows cur during a sweep, wrapping after the last table entry.
    function automatic int next_sweep_index(input int cur, input int n_settings);
        return (cur >= n_settings - 1) ? 0 : cur + 1;
    endfunction

endpackage

// File: rtl/tx_dwell_timer.sv
// Dwell counter for the auto-sweep: counts ACTIVE cycles spent on one setting and
// flags when the programmed dwell has elapsed. A dwell of 0 behaves like a dwell of 1.
module tx_dwell_timer #(
    parameter int DWELL_WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   en,
    input  logic                   clr,
    input  logic [DWELL_WIDTH-1:0] limit,
    output logic                   expire
);

    logic [DWELL_WIDTH-1:0] count;
    logic [DWELL_WIDTH-1:0] last;

    // Final count value for this dwell: max(limit,1)-1.
    assign last   = (limit == '0) ? '0 : limit - DWELL_WIDTH'(1);
    assign expire = (count == last);

    // Count enabled cycles; clear takes priority so a new setting always starts from 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            // NOTE: registers are written with <= so every flop samples pre-edge values.
            count <= '0;
        end else if (en) begin
            count <= count + DWELL_WIDTH'(1);
        end
    end

endmodule

// File: rtl/tx_setting_ctrl.sv
// Runtime sequencer for the TX FFE driver. Owns the emphasis setting index, accepts
// host setting changes, optionally sweeps all settings for link training, and mutes the
// driver input for a full delay-line length on each side of every change so the filter
// never mixes taps from two settings.
module tx_setting_ctrl
    import tx_setting_ctrl_pkg::*;
#(
    parameter int N_SETTINGS      = N_TX_SETTINGS,
    parameter int DEFAULT_SETTING = 10,
    parameter int DWELL_WIDTH     = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          in,
    output logic                          out,
    output logic [$clog2(N_SETTINGS)-1:0] setting,
    output logic                          settling,
    input  logic                          req_valid,
    input  logic [$clog2(N_SETTINGS)-1:0] req_setting,
    output logic                          req_ready,
    input  logic                          sweep_en,
    input  logic [DWELL_WIDTH-1:0]        sweep_dwell,
    output logic                          change_done,
    output logic                          range_err
);

    localparam int                    SETTING_W     = $clog2(N_SETTINGS);
    localparam logic [SETTING_W-1:0]  MAX_SETTING   = SETTING_W'(N_SETTINGS - 1);
    localparam logic [SETTING_W-1:0]  RESET_SETTING = SETTING_W'(DEFAULT_SETTING);
    localparam logic [CNT_WIDTH-1:0]  LAST_CNT      = CNT_WIDTH'(N_TAPS - 1);

    tx_ctrl_state_t         state;
    logic [CNT_WIDTH-1:0]   cnt;
    logic [SETTING_W-1:0]   target;
    logic [SETTING_W-1:0]   sweep_next;

    logic transfer;
    logic req_over;
    logic phase_done;
    logic sweep_expire;
    logic sweep_step;
    logic dwell_inc;
    logic dwell_clr;

    // req_ready is a registered copy of (state == ACTIVE), so this is the handshake.
    assign transfer   = req_valid & req_ready;
    assign req_over   = (req_setting > MAX_SETTING);
    assign phase_done = (cnt == LAST_CNT);
    assign sweep_next = SETTING_W'(next_sweep_index(int'(setting), N_SETTINGS));

    // A host transfer outranks a sweep expiry on the same edge.
    assign sweep_step = (state == ACTIVE) && !transfer && sweep_en && sweep_expire;

    // Dwell advances only while sweeping in ACTIVE; it freezes when sweep_en drops and
    // restarts from zero whenever a change completes.
    assign dwell_inc  = (state == ACTIVE) && sweep_en && !transfer && !sweep_expire;
    assign dwell_clr  = (state == SETTLE) && phase_done;

    tx_dwell_timer #(
        .DWELL_WIDTH (DWELL_WIDTH)
    ) u_dwell (
        .clk    (clk),
        .rst_n  (rst_n),
        .en     (dwell_inc),
        .clr    (dwell_clr),
        .limit  (sweep_dwell),
        .expire (sweep_expire)
    );

    // Sequencer FSM with registered data path and status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= SETTLE;
            cnt         <= '0;
            setting     <= RESET_SETTING;
            target      <= RESET_SETTING;
            out         <= 1'b0;
            settling    <= 1'b1;
            req_ready   <= 1'b0;
            change_done <= 1'b0;
            range_err   <= 1'b0;
        end else begin
            // NOTE: pulse outputs default low here so each assertion below lasts one cycle.
            change_done <= 1'b0;
            range_err   <= 1'b0;

            // Data passes only while the filter runs on a single, settled setting.
            out <= (state == ACTIVE) ? in : 1'b0;

            case (state)
                ACTIVE: begin
                    if (transfer) begin
                        target    <= req_over ? MAX_SETTING : req_setting;
                        range_err <= req_over;
                        cnt       <= '0;
                        state     <= DRAIN;
                        settling  <= 1'b1;
                        req_ready <= 1'b0;
                    end else if (sweep_step) begin
                        target    <= sweep_next;
                        cnt       <= '0;
                        state     <= DRAIN;
                        settling  <= 1'b1;
                        req_ready <= 1'b0;
                    end
                end

                DRAIN: begin
                    // Old-setting symbols are flushed; the index changes exactly here.
                    if (phase_done) begin
                        setting <= target;
                        cnt     <= '0;
                        state   <= SETTLE;
                    end else begin
                        cnt <= cnt + CNT_WIDTH'(1);
                    end
                end

                SETTLE: begin
                    // Delay line now holds only zeros under the new setting; resume data.
                    if (phase_done) begin
                        cnt         <= '0;
                        state       <= ACTIVE;
                        settling    <= 1'b0;
                        req_ready   <= 1'b1;
                        change_done <= 1'b1;
                    end else begin
                        cnt <= cnt + CNT_WIDTH'(1);
                    end
                end

                default: begin
                    // Unreachable encoding: recover through a full settle phase.
                    cnt       <= '0;
                    state     <= SETTLE;
                    settling  <= 1'b1;
                    req_ready <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tx_setting_ctrl.sv
// Self-checking bench for tx_setting_ctrl. A countdown-based behavioural model predicts
// every output each cycle; directed scenarios add latency and ordering checks on top.
module tb_tx_setting_ctrl;
    import tx_setting_ctrl_pkg::*;

    localparam int NS  = 11;
    localparam int DEF = 10;
    localparam int DW  = 16;
    localparam int SW  = $clog2(NS);
    localparam int NT  = N_TAPS;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          in = 1'b0;
    logic          req_valid = 1'b0;
    logic [SW-1:0] req_setting = '0;
    logic          sweep_en = 1'b0;
    logic [DW-1:0] sweep_dwell = '0;
    logic          out;
    logic [SW-1:0] setting;
    logic          settling;
    logic          req_ready;
    logic          change_done;
    logic          range_err;

    int n_checks = 0;
    int n_pass   = 0;

    // Model: m_busy counts remaining muted cycles (0 = accepting data and requests).
    int m_busy;
    int m_setting;
    int m_target;
    int m_dwell;
    bit m_out;
    bit m_done;
    bit m_rerr;

    int run_set[$];
    int run_len[$];

    always #5 clk = ~clk;

    tx_setting_ctrl #(
        .N_SETTINGS      (NS),
        .DEFAULT_SETTING (DEF),
        .DWELL_WIDTH     (DW)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in          (in),
        .out         (out),
        .setting     (setting),
        .settling    (settling),
        .req_valid   (req_valid),
        .req_setting (req_setting),
        .req_ready   (req_ready),
        .sweep_en    (sweep_en),
        .sweep_dwell (sweep_dwell),
        .change_done (change_done),
        .range_err   (range_err)
    );

    function automatic void model_reset();
        m_busy    = NT;
        m_setting = DEF;
        m_target  = DEF;
        m_dwell   = 0;
        m_out     = 1'b0;
        m_done    = 1'b0;
        m_rerr    = 1'b0;
    endfunction

    // One clock edge of the specified behaviour, using the inputs held before the edge.
    function automatic void model_step();
        int lim;
        lim    = (sweep_dwell == '0) ? 1 : int'(sweep_dwell);
        m_done = 1'b0;
        m_rerr = 1'b0;
        m_out  = (m_busy == 0) ? in : 1'b0;
        if (m_busy == 0) begin
            if (req_valid) begin
                m_rerr   = (int'(req_setting) > NS - 1);
                m_target = m_rerr ? NS - 1 : int'(req_setting);
                m_busy   = 2 * NT;
            end else if (sweep_en && m_dwell == lim - 1) begin
                m_target = (m_setting + 1) % NS;
                m_busy   = 2 * NT;
            end else if (sweep_en) begin
                m_dwell++;
            end
        end else begin
            m_busy--;
            if (m_busy == NT) m_setting = m_target;
            if (m_busy == 0) begin
                m_done  = 1'b1;
                m_dwell = 0;
            end
        end
    endfunction

    function automatic logic [8:0] model_vec();
        return {m_out, SW'(m_setting), (m_busy != 0), (m_busy == 0), m_done, m_rerr};
    endfunction

    function automatic logic [8:0] dut_vec();
        return {out, setting, settling, req_ready, change_done, range_err};
    endfunction

    // Advance one clock; outputs are sampled afterwards on the falling edge.
    task automatic tick();
        @(posedge clk);
        if (rst_n) model_step();
        @(negedge clk);
    endtask

    task automatic wait_ready(input string tag);
        int waited;
        waited = 0;
        while (req_ready !== 1'b1 && waited < 8 * NT + 20) begin
            tick();
            waited++;
        end
        if (req_ready !== 1'b1) $display("FAIL %s_ready_timeout: req_ready=%b after %0d cycles, required 1", tag, req_ready, waited);
        else n_pass++;
        n_checks++;
    endtask

    // Run n cycles with current inputs, recording each ACTIVE run as (setting, length).
    task automatic run_track(input string tag, input int n);
        int cur_set;
        int cur_len;
        run_set.delete();
        run_len.delete();
        cur_set = -1;
        cur_len = 0;
        for (int c = 0; c < n; c++) begin
            if (req_ready === 1'b1) begin
                if (int'(setting) != cur_set) begin
                    if (cur_len > 0) begin
                        run_set.push_back(cur_set);
                        run_len.push_back(cur_len);
                    end
                    cur_set = int'(setting);
                    cur_len = 0;
                end
                cur_len++;
            end
            tick();
            if (dut_vec() !== model_vec()) $display("FAIL %s[%0d]: dut {out,setting,settling,ready,done,rerr}=%b model=%b", tag, c, dut_vec(), model_vec());
            else n_pass++;
            n_checks++;
        end
        if (cur_len > 0) begin
            run_set.push_back(cur_set);
            run_len.push_back(cur_len);
        end
    endtask

    task automatic test_reset();
        int ready_at;
        #2 rst_n = 1'b0;
        model_reset();
        @(negedge clk);
        if (dut_vec() !== 9'b0_1010_1_0_0_0) $display("FAIL reset_state: dut=%b required=%b", dut_vec(), 9'b0_1010_1_0_0_0);
        else n_pass++;
        n_checks++;
        tick();
        rst_n = 1'b1;
        ready_at = -1;
        for (int k = 1; k <= NT + 2; k++) begin
            tick();
            if (dut_vec() !== model_vec()) $display("FAIL reset_release[%0d]: dut=%b model=%b", k, dut_vec(), model_vec());
            else n_pass++;
            n_checks++;
            if (ready_at < 0 && req_ready === 1'b1) ready_at = k;
        end
        if (ready_at !== NT) $display("FAIL reset_to_active: ready after %0d cycles, required %0d", ready_at, NT);
        else n_pass++;
        n_checks++;

        // Abort a change in the middle of DRAIN.
        req_valid   = 1'b1;
        req_setting = SW'(2);
        tick();
        req_valid = 1'b0;
        tick();
        tick();
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        if (dut_vec() !== 9'b0_1010_1_0_0_0) $display("FAIL reset_mid_drain: dut=%b required=%b", dut_vec(), 9'b0_1010_1_0_0_0);
        else n_pass++;
        n_checks++;
        @(negedge clk);
        rst_n = 1'b1;
        ready_at = -1;
        for (int k = 1; k <= NT + 1; k++) begin
            in = 1'($urandom);
            tick();
            if (dut_vec() !== model_vec()) $display("FAIL reset_recover[%0d]: dut=%b model=%b", k, dut_vec(), model_vec());
            else n_pass++;
            n_checks++;
            if (ready_at < 0 && req_ready === 1'b1) ready_at = k;
        end
        if (ready_at !== NT) $display("FAIL reset_recover_active: ready after %0d cycles, required %0d", ready_at, NT);
        else n_pass++;
        n_checks++;
    endtask

    // Host change: setting moves N_TAPS edges after the transfer edge; change_done is
    // raised by edge 2*N_TAPS, i.e. in the (2*N_TAPS+1)th cycle counting the transfer cycle.
    task automatic test_change(input string tag, input logic [SW-1:0] req, input int exp_set);
        int set_edge;
        int done_edge;
        logic rerr_seen;
        logic ready_seen;
        logic [SW-1:0] prev;
        wait_ready(tag);
        prev        = setting;
        req_valid   = 1'b1;
        req_setting = req;
        in          = 1'($urandom);
        tick();
        req_valid  = 1'b0;
        rerr_seen  = range_err;
        ready_seen = req_ready;
        if (dut_vec() !== model_vec()) $display("FAIL %s_xfer: dut=%b model=%b", tag, dut_vec(), model_vec());
        else n_pass++;
        n_checks++;
        set_edge  = -1;
        done_edge = -1;
        for (int k = 1; k <= 2 * NT + 1; k++) begin
            in = 1'($urandom);
            tick();
            if (dut_vec() !== model_vec()) $display("FAIL %s[%0d]: dut=%b model=%b", tag, k, dut_vec(), model_vec());
            else n_pass++;
            n_checks++;
            if (set_edge < 0 && setting !== prev) set_edge = k;
            if (change_done === 1'b1) done_edge = k;
        end
        if (rerr_seen !== (int'(req) > NS - 1)) $display("FAIL %s_range_err: got %b required %b", tag, rerr_seen, (int'(req) > NS - 1));
        else n_pass++;
        n_checks++;
        if (ready_seen !== 1'b0) $display("FAIL %s_ready_drop: req_ready=%b required 0", tag, ready_seen);
        else n_pass++;
        n_checks++;
        if (set_edge != NT || int'(setting) != exp_set) $display("FAIL %s_setting: changed at edge %0d to %0d, required edge %0d value %0d", tag, set_edge, setting, NT, exp_set);
        else n_pass++;
        n_checks++;
        if (done_edge != 2 * NT) $display("FAIL %s_done_latency: edge %0d required %0d", tag, done_edge, 2 * NT);
        else n_pass++;
        n_checks++;
    endtask

    task automatic test_sweep();
        test_change("sweep_prep", SW'(9), 9);
        sweep_dwell = DW'(4);
        sweep_en    = 1'b1;
        run_track("sweep", 3 * (4 + 2 * NT) + 2);
        sweep_en = 1'b0;
        if (run_set.size() < 3) $display("FAIL sweep_runs: saw %0d active runs, required at least 3", run_set.size());
        else if (run_set[0] != 9 || run_set[1] != 10 || run_set[2] != 0) $display("FAIL sweep_order: %0d,%0d,%0d required 9,10,0", run_set[0], run_set[1], run_set[2]);
        else if (run_len[0] != 4 || run_len[1] != 4 || run_len[2] != 4) $display("FAIL sweep_dwell: %0d,%0d,%0d required 4,4,4", run_len[0], run_len[1], run_len[2]);
        else n_pass++;
        n_checks++;
    endtask

    task automatic test_collision();
        test_change("collide_prep", SW'(4), 4);
        sweep_dwell = DW'(3);
        sweep_en    = 1'b1;
        for (int k = 0; k < 2; k++) begin
            tick();
            if (dut_vec() !== model_vec()) $display("FAIL collide_dwell[%0d]: dut=%b model=%b", k, dut_vec(), model_vec());
            else n_pass++;
            n_checks++;
        end
        // Third ACTIVE cycle: dwell expires and the host requests on the same edge.
        req_valid   = 1'b1;
        req_setting = SW'(7);
        tick();
        req_valid = 1'b0;
        if (dut_vec() !== model_vec()) $display("FAIL collide_xfer: dut=%b model=%b", dut_vec(), model_vec());
        else n_pass++;
        n_checks++;
        run_track("collide", 2 * NT + 3 + 2 * NT + 2);
        sweep_en = 1'b0;
        if (run_set.size() < 2) $display("FAIL collide_runs: saw %0d active runs, required at least 2", run_set.size());
        else if (run_set[0] != 7 || run_len[0] != 3 || run_set[1] != 8) $display("FAIL collide_order: (%0d,%0d) then %0d, required (7,3) then 8", run_set[0], run_len[0], run_set[1]);
        else n_pass++;
        n_checks++;
    endtask

    task automatic test_prbs();
        logic [6:0] lfsr;
        logic       bit_in;
        logic       exp_out;
        int         bad;
        wait_ready("prbs");
        lfsr = 7'h7F;
        bad  = 0;
        for (int k = 0; k < 140; k++) begin
            bit_in  = lfsr[6] ^ lfsr[5];
            lfsr    = {lfsr[5:0], bit_in};
            in      = bit_in;
            exp_out = bit_in;
            tick();
            if (out !== exp_out || settling !== 1'b0) begin
                bad++;
                $display("FAIL prbs[%0d]: out=%b settling=%b required out=%b settling=0", k, out, settling, exp_out);
            end else n_pass++;
            n_checks++;
            if (dut_vec() !== model_vec()) $display("FAIL prbs_model[%0d]: dut=%b model=%b", k, dut_vec(), model_vec());
            else n_pass++;
            n_checks++;
        end
    endtask

    task automatic test_random();
        sweep_dwell = DW'($urandom_range(0, 5));
        for (int k = 0; k < 600; k++) begin
            in          = 1'($urandom);
            req_valid   = ($urandom_range(0, 5) == 0);
            req_setting = SW'($urandom_range(0, 15));
            if ($urandom_range(0, 9) == 0) sweep_en = ~sweep_en;
            tick();
            if (dut_vec() !== model_vec()) $display("FAIL random[%0d]: dut=%b model=%b", k, dut_vec(), model_vec());
            else n_pass++;
            n_checks++;
        end
        req_valid = 1'b0;
        sweep_en  = 1'b0;
    endtask

    initial begin
        test_reset();
        test_change("host_req3", SW'(3), 3);
        test_change("range15", SW'(15), 10);
        test_sweep();
        test_collision();
        test_prbs();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
